// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the stall controller: stop polarity, stall bit map, arbiter state
// encodings and the per-hazard stall vectors.
package stall_ctrl_pkg;

  localparam logic Stop    = 1'b1;
  localparam logic NotStop = 1'b0;

  localparam int unsigned StallW = 6;

  typedef enum int unsigned {
    BitPc    = 0,
    BitIfId  = 1,
    BitIdEx  = 2,
    BitExMem = 3,
    BitMemWb = 4,
    BitRsvd  = 5
  } stall_bit_e;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StServeIf  = 2'b01,
    StServeMem = 2'b10
  } arb_state_e;

  // Each vector stops every register up to and including the one whose successor takes a bubble.
  localparam logic [StallW-1:0] MemStall  = 6'b001111;
  localparam logic [StallW-1:0] LoadStall = 6'b000011;
  localparam logic [StallW-1:0] IfStall   = 6'b000001;

endpackage

// File: rtl/stall_ctrl_mem_arbiter.sv
// Single memory port arbiter between IF and MEM; MEM wins in IDLE. Completion is fixed-latency
// by default, or driven by mem_done when STALL_CTRL_MEM_DONE_HANDSHAKE_EN is defined.
module stall_ctrl_mem_arbiter
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic if_req,
  input  logic mem_req,
  input  logic mem_done,
  output logic grant_if,
  output logic grant_mem,
  output logic serving_if,
  output logic serving_mem,
  output logic done
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

`ifndef STALL_CTRL_MEM_DONE_HANDSHAKE_EN
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LATENCY - 1);
  logic unused_mem_done;
  assign unused_mem_done = mem_done;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Clearing here means every serve state is entered with cnt = 0.
        cnt_d = '0;
        if (mem_req) begin
          state_d = StServeMem;
        end else if (if_req) begin
          state_d = StServeIf;
        end
      end
      StServeIf, StServeMem: begin
`ifdef STALL_CTRL_MEM_DONE_HANDSHAKE_EN
        done  = mem_done;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);
`else
        done  = (cnt_q == LastCnt);
        cnt_d = cnt_q + CntW'(1);
`endif
        if (done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign serving_if  = (state_q == StServeIf);
  assign serving_mem = (state_q == StServeMem);
  assign grant_if    = serving_if;
  assign grant_mem   = serving_mem;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: builds the stall bus, branch flush and fetch discard around
// the memory port arbiter. Optional handshake completion: STALL_CTRL_MEM_DONE_HANDSHAKE_EN.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 3,
  parameter int unsigned STALL_W     = StallW
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               if_req,
  input  logic               mem_req,
  input  logic               id_load_hazard,
  input  logic               ex_branch_taken,
  input  logic               mem_done,
  output logic               grant_if,
  output logic               grant_mem,
  output logic               if_discard,
  output logic [STALL_W-1:0] stall,
  output logic               flush
);

  logic              serving_if;
  logic              serving_mem;
  logic              done;
  logic              if_pend;
  logic              mem_pend;
  logic              discard_set;
  logic              if_discard_q, if_discard_d;
  logic [StallW-1:0] stall_vec;

  stall_ctrl_mem_arbiter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_mem_arbiter (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .if_req     (if_req),
    .mem_req    (mem_req),
    .mem_done   (mem_done),
    .grant_if   (grant_if),
    .grant_mem  (grant_mem),
    .serving_if (serving_if),
    .serving_mem(serving_mem),
    .done       (done)
  );

  always_comb begin
    // A requester being served stops waiting on its completion cycle, even if still requesting.
    mem_pend = serving_mem ? ~done : mem_req;
    if_pend  = serving_if  ? ~done : if_req;

    stall_vec = '0;
    if (rst_in) begin
      if (mem_pend)       stall_vec = stall_vec | MemStall;
      if (id_load_hazard) stall_vec = stall_vec | LoadStall;
      if (if_pend)        stall_vec = stall_vec | IfStall;
    end
    stall_vec[BitRsvd] = NotStop;

    // A branch sitting in a held EX is not retired yet; flush on the release cycle instead.
    flush = rst_in & ex_branch_taken & (stall_vec[BitExMem] != Stop);

    discard_set  = flush & (serving_if | (~serving_if & ~serving_mem & if_req));
    if_discard   = if_discard_q | discard_set;
    if_discard_d = if_discard & ~(serving_if & done);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      if_discard_q <= 1'b0;
    end else begin
      if_discard_q <= if_discard_d;
    end
  end

  assign stall = STALL_W'(stall_vec);

  grants_exclusive_a : assert property (@(posedge clk_in) disable iff (!rst_in)
    !(grant_if && grant_mem));

endmodule
